// File: rtl/radix4_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : radix4_pkg
//  Purpose  : Shared types and constants for the radix-4 sequential divider
//  Revision : 1.0  initial release
// ============================================================================
package radix4_pkg;

  // Divider control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Quotient bits retired per iteration
  localparam int RADIX_BITS = 2;

  // Number of radix-4 iterations needed for a w-bit operand
  function automatic int digits_for(input int w);
    return w / RADIX_BITS;
  endfunction

endpackage
`default_nettype wire

// File: rtl/radix4_div_digit.sv
`default_nettype none
// ============================================================================
//  Module   : radix4_div_digit
//  Purpose  : One radix-4 restoring division step (combinational).
//             Shifts the partial remainder left by 2, inserts the next two
//             dividend bits, tries q = 3,2,1 and keeps the largest that
//             leaves a non-negative remainder.
//  Revision : 1.0  initial release
// ============================================================================
module radix4_div_digit
  import radix4_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W+1:0] rem_in,
  input  logic [1:0]   nbits,
  input  logic [W-1:0] d,
  output logic [W+1:0] rem_out,
  output logic [1:0]   q
);

  // One guard bit above the largest trial value (T < 4D < 2^(W+2)) so the
  // top bit of each difference is a reliable sign.
  localparam int TW = W + 3;

  logic [TW-1:0] t_val;
  logic [TW-1:0] d1, d2, d3;
  logic [TW-1:0] diff1, diff2, diff3;

  // The remainder entering a step is always below D, so truncating the
  // shifted value to TW bits drops only zero bits.
  assign t_val = TW'({rem_in, nbits});
  assign d1    = TW'(d);
  assign d2    = TW'({d, 1'b0});
  assign d3    = d1 + d2;

  assign diff1 = t_val - d1;
  assign diff2 = t_val - d2;
  assign diff3 = t_val - d3;

  // Pick the largest digit whose trial difference is non-negative
  always_comb begin
    q       = 2'd0;
    rem_out = t_val[W+1:0];
    if (!diff3[TW-1]) begin
      q       = 2'd3;
      rem_out = diff3[W+1:0];
    end else if (!diff2[TW-1]) begin
      q       = 2'd2;
      rem_out = diff2[W+1:0];
    end else if (!diff1[TW-1]) begin
      q       = 2'd1;
      rem_out = diff1[W+1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/radix4_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : radix4_div_seq
//  Purpose  : Sequential unsigned radix-4 restoring divider with a
//             start/done handshake. Retires two quotient bits per clock.
//  Revision : 1.0  initial release
// ============================================================================
module radix4_div_seq
  import radix4_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int            DIGITS     = digits_for(W);
  localparam int            CW         = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] DIGITS_CNT = CW'(DIGITS);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   d_reg;
  logic [W-1:0]   n_reg;
  logic [W-1:0]   q_reg;
  logic [W+1:0]   r_reg;
  logic [W+1:0]   r_next;
  logic [1:0]     q_digit;
  logic [W-1:0]   q_shift;
  logic           accept;
  logic           divisor_zero;
  logic           last_digit;

  assign accept       = start && ready;
  assign divisor_zero = (divisor == '0);
  assign last_digit   = (cnt == CNT_ONE);

  radix4_div_digit #(
    .W (W)
  ) u_digit (
    .rem_in  (r_reg),
    .nbits   (n_reg[W-1:W-2]),
    .d       (d_reg),
    .rem_out (r_next),
    .q       (q_digit)
  );

  // Quotient shift register with the new digit appended at the bottom
  generate
    if (W == RADIX_BITS) begin : g_q_narrow
      assign q_shift = q_digit;
    end else begin : g_q_wide
      assign q_shift = {q_reg[W-3:0], q_digit};
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) state_next = divisor_zero ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_digit) state_next = ST_DONE;
      end
      ST_DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (start) state_next = divisor_zero ? ST_DONE : ST_RUN;
        else       state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand capture, per-digit iteration and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      d_reg       <= '0;
      n_reg       <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      d_reg       <= divisor;
      n_reg       <= dividend;
      q_reg       <= '0;
      r_reg       <= '0;
      cnt         <= DIGITS_CNT;
      div_by_zero <= 1'b0;
      // Zero divisor short-circuits straight to a saturated result
      if (divisor_zero) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == ST_RUN) begin
      n_reg <= n_reg << RADIX_BITS;
      r_reg <= r_next;
      q_reg <= q_shift;
      cnt   <= cnt - CNT_ONE;
      if (last_digit) begin
        quotient  <= q_shift;
        remainder <= r_next[W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_radix4_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_radix4_div_seq
//  Purpose  : Self-checking bench for radix4_div_seq (W=8)
//  Revision : 1.0  initial release
// ============================================================================
module tb_radix4_div_seq;

  localparam int W   = 8;
  localparam int LIM = 20;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready, busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  radix4_div_seq #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Reference model: plain integer division, saturated result on zero divisor
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0; e.lat = W / 2 + 1;
    end
    return e;
  endfunction

  // Drive one start, push the expectation, then wait (bounded) for done.
  // lat counts clock edges from the start edge to the cycle where done is seen.
  task automatic issue_and_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                                output int lat, output int busy_n, output bit timeout);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    sb.push_back(model(a, b));
    lat = 0; busy_n = 0; timeout = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
      start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
      if (busy) busy_n++;
    end while (!done && lat < LIM);
    if (!done) timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1)     begin failures++; $display("FAIL reset_ready got %b expected 1", ready); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done got %b expected 0", done); end
    checks++; if (quotient !== '0)    begin failures++; $display("FAIL reset_quotient got %0d expected 0", quotient); end
    checks++; if (remainder !== '0)   begin failures++; $display("FAIL reset_remainder got %0d expected 0", remainder); end
    checks++; if (div_by_zero !== 0)  begin failures++; $display("FAIL reset_dz got %b expected 0", div_by_zero); end
  endtask

  task automatic test_nominal();
    int lat, bn; bit to; exp_t e;
    issue_and_wait(8'd201, 8'd7, lat, bn, to);
    e = sb.pop_front();
    checks++; if (to)                   begin failures++; $display("FAIL nominal_timeout got no done expected done"); end
    checks++; if (lat != e.lat)         begin failures++; $display("FAIL nominal_latency got %0d expected %0d", lat, e.lat); end
    checks++; if (bn != 4)              begin failures++; $display("FAIL nominal_busy_cycles got %0d expected 4", bn); end
    checks++; if (quotient !== e.q)     begin failures++; $display("FAIL nominal_quotient got %0d expected %0d", quotient, e.q); end
    checks++; if (remainder !== e.r)    begin failures++; $display("FAIL nominal_remainder got %0d expected %0d", remainder, e.r); end
    checks++; if (div_by_zero !== e.dz) begin failures++; $display("FAIL nominal_dz got %b expected %b", div_by_zero, e.dz); end
    checks++; if (quotient !== 8'd28 || remainder !== 8'd5)
      begin failures++; $display("FAIL nominal_const got q=%0d r=%0d expected q=28 r=5", quotient, remainder); end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] as [7] = '{8'd5, 8'd0, 8'd255, 8'd255, 8'd200, 8'd1, 8'd254};
    logic [W-1:0] bs [7] = '{8'd9, 8'd13, 8'd1, 8'd255, 8'd3, 8'd2, 8'd128};
    int lat, bn; bit to; exp_t e;
    for (int i = 0; i < 7; i++) begin
      issue_and_wait(as[i], bs[i], lat, bn, to);
      e = sb.pop_front();
      checks++; if (to || lat != e.lat) begin failures++; $display("FAIL bound_latency[%0d] got %0d expected %0d", i, lat, e.lat); end
      checks++; if (quotient !== e.q)   begin failures++; $display("FAIL bound_quotient[%0d] got %0d expected %0d", i, quotient, e.q); end
      checks++; if (remainder !== e.r)  begin failures++; $display("FAIL bound_remainder[%0d] got %0d expected %0d", i, remainder, e.r); end
      checks++; if (div_by_zero !== e.dz) begin failures++; $display("FAIL bound_dz[%0d] got %b expected %b", i, div_by_zero, e.dz); end
    end
  endtask

  task automatic test_div_by_zero();
    int lat, bn; bit to; exp_t e;
    issue_and_wait(8'd100, 8'd0, lat, bn, to);
    e = sb.pop_front();
    checks++; if (to || lat != 1)       begin failures++; $display("FAIL dz_latency got %0d expected 1", lat); end
    checks++; if (quotient !== 8'd255)  begin failures++; $display("FAIL dz_quotient got %0d expected 255", quotient); end
    checks++; if (remainder !== e.r)    begin failures++; $display("FAIL dz_remainder got %0d expected %0d", remainder, e.r); end
    checks++; if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dz_flag got %b expected 1", div_by_zero); end
    issue_and_wait(8'd9, 8'd2, lat, bn, to);
    e = sb.pop_front();
    checks++; if (to || lat != e.lat)   begin failures++; $display("FAIL dz_next_latency got %0d expected %0d", lat, e.lat); end
    checks++; if (quotient !== e.q || remainder !== e.r)
      begin failures++; $display("FAIL dz_next_result got q=%0d r=%0d expected q=%0d r=%0d", quotient, remainder, e.q, e.r); end
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL dz_next_flag got %b expected 0", div_by_zero); end
  endtask

  task automatic test_ignore_start();
    int lat; exp_t e;
    @(negedge clk);
    start = 1'b1; dividend = 8'd201; divisor = 8'd7;
    sb.push_back(model(8'd201, 8'd7));
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      // Pulse start with different operands while busy
      if (lat == 2) begin start = 1'b1; dividend = 8'd50; divisor = 8'd3; end
      else          begin start = 1'b0; dividend = 8'd17; divisor = 8'd0; end
    end while (!done && lat < LIM);
    e = sb.pop_front();
    checks++; if (!done || lat != e.lat) begin failures++; $display("FAIL ignore_latency got %0d expected %0d", lat, e.lat); end
    checks++; if (quotient !== e.q || remainder !== e.r)
      begin failures++; $display("FAIL ignore_result got q=%0d r=%0d expected q=%0d r=%0d", quotient, remainder, e.q, e.r); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL ignore_idle got done=%b ready=%b expected done=0 ready=1", done, ready); end
  endtask

  task automatic test_back_to_back();
    int lat, bn; bit to; exp_t e;
    issue_and_wait(8'd100, 8'd9, lat, bn, to);
    e = sb.pop_front();
    checks++; if (to || quotient !== e.q || remainder !== e.r)
      begin failures++; $display("FAIL b2b_first got q=%0d r=%0d expected q=%0d r=%0d", quotient, remainder, e.q, e.r); end
    // Still in the done cycle: raise start for an immediate second operation
    start = 1'b1; dividend = 8'd77; divisor = 8'd6;
    sb.push_back(model(8'd77, 8'd6));
    lat = 0;
    @(posedge clk); #1;
    lat++;
    start = 1'b0; dividend = '0; divisor = '0;
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got done=%b busy=%b expected done=0 busy=1", done, busy); end
    while (!done && lat < LIM) begin @(posedge clk); #1; lat++; end
    e = sb.pop_front();
    checks++; if (!done || lat != e.lat) begin failures++; $display("FAIL b2b_latency got %0d expected %0d", lat, e.lat); end
    checks++; if (quotient !== e.q || remainder !== e.r)
      begin failures++; $display("FAIL b2b_second got q=%0d r=%0d expected q=%0d r=%0d", quotient, remainder, e.q, e.r); end
  endtask

  task automatic test_reset_mid_run();
    int lat, bn; bit to; bit saw_done; exp_t e;
    @(negedge clk);
    start = 1'b1; dividend = 8'd201; divisor = 8'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checks++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      begin failures++; $display("FAIL midrst_ctrl got r=%b b=%b d=%b expected r=1 b=0 d=0", ready, busy, done); end
    checks++; if (quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0)
      begin failures++; $display("FAIL midrst_outputs got q=%0d r=%0d dz=%b expected 0 0 0", quotient, remainder, div_by_zero); end
    saw_done = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
    checks++; if (saw_done) begin failures++; $display("FAIL midrst_no_done got done=1 expected 0"); end
    issue_and_wait(8'd201, 8'd7, lat, bn, to);
    e = sb.pop_front();
    checks++; if (to || lat != e.lat) begin failures++; $display("FAIL midrst_fresh_latency got %0d expected %0d", lat, e.lat); end
    checks++; if (quotient !== e.q || remainder !== e.r)
      begin failures++; $display("FAIL midrst_fresh_result got q=%0d r=%0d expected q=%0d r=%0d", quotient, remainder, e.q, e.r); end
  endtask

  task automatic test_random();
    int lat, bn; bit to; exp_t e;
    for (int i = 0; i < 20; i++) begin
      issue_and_wait(W'($urandom), W'($urandom_range(1, 255)), lat, bn, to);
      e = sb.pop_front();
      checks++; if (to || quotient !== e.q || remainder !== e.r || lat != e.lat)
        begin failures++; $display("FAIL random[%0d] got q=%0d r=%0d lat=%0d expected q=%0d r=%0d lat=%0d", i, quotient, remainder, lat, e.q, e.r, e.lat); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_boundaries();
    test_div_by_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got %0d expected 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
